child_response_collector: RTL
=============================

// Module: child_response_collector
// PURPOSE
//  Fan-in counterpart to the root/leaf instance fan-out: merges response streams from NUM_CHILD
//  leaf instances into one tagged stream toward the parent. Arbitration is round-robin, with one
//  registered output stage. Each output beat carries the index of its source child (0..NUM_CHILD-1).
//  Sits one level above the leaf instances, in the parent module.
// PARAMETERS
//  NUM_CHILD  5   number of child request ports (>=2)
//  DATA_W     16  payload width per child
//  IDX_W      $clog2(NUM_CHILD)  width of source tag (derived, do not override)
// PORTS
//  clk          in   1                  clock, all logic on rising edge
//  rst          in   1                  synchronous, active-high reset
//  en           in   1                  1 = grant requests; 0 = stop granting, drain, go idle
//  child_valid  in   NUM_CHILD          per-child beat valid
//  child_data   in   NUM_CHILD*DATA_W   child i payload at [i*DATA_W +: DATA_W]
//  child_ready  out  NUM_CHILD          one-hot (or zero) accept strobe per child
//  out_valid    out  1                  output beat valid
//  out_data     out  DATA_W             granted payload
//  out_idx      out  IDX_W              source child index
//  out_ready    in   1                  downstream accept
//  idle         out  1                  1 = state IDLE and output stage empty
// BEHAVIOUR
//  - Reset: state=IDLE, out_valid=0, out_data=0, out_idx=0, rr_ptr=0, idle=1; child_ready=0 while rst=1.
//  - Handshake: a transfer occurs when valid&ready are both high at the clock edge. Producers must
//    hold valid/data stable until accepted. out_valid is never dropped before out_ready.
//  - Output stage loads when it is empty, or when it is full and draining (out_valid&out_ready).
//    Back-to-back throughput is 1 beat/cycle.
//  - Latency: child beat accepted in cycle N -> out_valid=1 with that data in cycle N+1.
//  - child_ready: combinational; at most one bit set. Bit w is set only when state=RUN, the
//    output stage can load, child_valid[w]=1, and w is the first requester at or after rr_ptr
//    (modulo NUM_CHILD). child_ready never depends on out_ready except through the load condition.
//  - rr_ptr: after a grant to w, rr_ptr <= (w==NUM_CHILD-1) ? 0 : w+1 (wraps). Unchanged without a grant.
//  - No requesters -> no grant; the output stage empties once the held beat is accepted.
//  - FSM:
//      IDLE  --en=1--> RUN
//      RUN   --en=0--> DRAIN   (no grant in the cycle en is seen low)
//      DRAIN --output stage empty--> IDLE;  DRAIN --en=1--> RUN
//      IDLE with en=0 stays IDLE; grants occur only in RUN.
//  - idle = (state==IDLE) & ~out_valid.
//  - Reset mid-transfer: the held output beat is discarded and any child_ready pulse that cycle is void.
// CONFIGURATION
//  - COLLECTOR_PARITY_EN defined: adds output port out_parity (1 bit), registered with out_data.
//      out_parity = ^{out_idx,out_data} (even parity over tag+payload); reset 0.
//  - Not defined: port absent, no parity logic; all other behaviour identical.
// STRUCTURE
//  - Package collector_pkg:
//      DATA_W default constant;
//      typedef enum logic [1:0] {IDLE, RUN, DRAIN} coll_state_e;
//      function rr_next(ptr, n) implementing the wrap increment.
//  - One sub-module, rr_arbiter: inputs req[NUM_CHILD], ptr, en_grant;
//    outputs gnt one-hot, gnt_idx, any. Purely combinational.
//  - Top holds the FSM, rr_ptr and output register stage.
// TESTING
//  1. rst=1 for 2 cycles with all child_valid=1 -> child_ready=0, out_valid=0, idle=1 throughout.
//  2. en=1, child_valid=5'b11111, out_ready=1 -> grants 0,1,2,3,4,0 on consecutive cycles;
//     out_idx follows one cycle later.
//  3. en=1, only child 3 valid (data 16'hBEEF), out_ready=0 for 4 cycles -> one grant, then
//     out_valid=1, out_data=BEEF, out_idx=3 held; no further child_ready until out_ready=1.
//  4. Stream from child 4 then child 0 only -> rr_ptr wraps 4->0; child 0 granted next cycle,
//     no bubble.
//  5. Drop en mid-stream with a beat held and out_ready=0 -> DRAIN, no grants; out_ready=1 ->
//     beat delivered, next cycle IDLE, idle=1.
//  6. With COLLECTOR_PARITY_EN, idx=2, data=16'h0001 -> out_parity=0; idx=1, data=16'h0001 ->
//     out_parity=0; idx=1, data=0 -> out_parity=1.

Source files
------------

// File: rtl/collector_pkg.sv
// Shared types and helpers for the child response collector.
package collector_pkg;

   localparam int unsigned DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } coll_state_e;

   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr == n - 32'd1) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
module rr_arbiter #(
   parameter int unsigned NUM_CHILD = 5,
   parameter int unsigned IDX_W     = 3
) (
   input  logic [NUM_CHILD-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   input  logic                 en_grant,
   output logic [NUM_CHILD-1:0] gnt,
   output logic [IDX_W-1:0]     gnt_idx,
   output logic                 any
);

   always_comb begin
      int unsigned s;
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      s       = 0;
      for (int unsigned k = 0; k < NUM_CHILD; k++) begin
         s = 32'(ptr) + k;
         if (s >= NUM_CHILD) s = s - NUM_CHILD;
         if (en_grant && !any && req[IDX_W'(s)]) begin
            gnt[IDX_W'(s)] = 1'b1;
            gnt_idx        = IDX_W'(s);
            any            = 1'b1;
         end
      end
   end

endmodule

// File: rtl/child_response_collector.sv
// Round-robin fan-in of NUM_CHILD response streams into one tagged, registered output stream.
// Define COLLECTOR_PARITY_EN to add the out_parity port (even parity over out_idx and out_data).
module child_response_collector
   import collector_pkg::*;
#(
   parameter int unsigned NUM_CHILD = 5,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   localparam int unsigned IDX_W    = $clog2(NUM_CHILD)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic [NUM_CHILD-1:0]        child_valid,
   input  logic [NUM_CHILD*DATA_W-1:0] child_data,
   output logic [NUM_CHILD-1:0]        child_ready,
   output logic                        out_valid,
   output logic [DATA_W-1:0]           out_data,
   output logic [IDX_W-1:0]            out_idx,
`ifdef COLLECTOR_PARITY_EN
   output logic                        out_parity,
`endif
   input  logic                        out_ready,
   output logic                        idle
);

   coll_state_e       state_q, state_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [IDX_W-1:0]  out_idx_q, out_idx_d;
   logic              load_ok, en_grant, any;
   logic [NUM_CHILD-1:0] gnt;
   logic [IDX_W-1:0]  gnt_idx;

   // Stage can take a new beat when empty or when its current beat leaves this cycle.
   assign load_ok  = ~out_valid_q | out_ready;
   assign en_grant = ~rst & en & (state_q == RUN) & load_ok;

   rr_arbiter #(
      .NUM_CHILD (NUM_CHILD),
      .IDX_W     (IDX_W)
   ) u_arb (
      .req      (child_valid),
      .ptr      (rr_ptr_q),
      .en_grant (en_grant),
      .gnt      (gnt),
      .gnt_idx  (gnt_idx),
      .any      (any)
   );

   assign child_ready = gnt;
   assign rr_ptr_d    = any ? IDX_W'(rr_next(32'(gnt_idx), NUM_CHILD)) : rr_ptr_q;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      if (load_ok) begin
         out_valid_d = any;
         if (any) begin
            out_idx_d  = gnt_idx;
            out_data_d = '0;
            for (int i = 0; i < NUM_CHILD; i++) begin
               if (gnt[i]) out_data_d = out_data_d | child_data[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (en) state_d = RUN;
         RUN:     if (!en) state_d = DRAIN;
         DRAIN: begin
            if (en)                state_d = RUN;
            else if (!out_valid_d) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
      end
   end

`ifdef COLLECTOR_PARITY_EN
   logic out_parity_q;

   always_ff @(posedge clk) begin
      if (rst)                 out_parity_q <= 1'b0;
      else if (load_ok && any) out_parity_q <= ^{out_idx_d, out_data_d};
   end

   assign out_parity = out_parity_q;
`endif

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign idle      = (state_q == IDLE) & ~out_valid_q;

endmodule
